// File: rtl/boss_bullet_collide.sv
// rtl/boss_bullet_collide.sv - boss bullet / player overlap counter, hit commit and lives sequencer
// Optional feature macro: BOSS_COLLIDE_BLINK_EN (player_blink toggling during invulnerability)
module boss_bullet_collide #(
  parameter int START_LIVES    = 3,
  parameter int HIT_THRESHOLD  = 4,
  parameter int COLLIDE_FRAMES = 2,
  parameter int INVULN_FRAMES  = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       pixel_valid,
  input  logic       boss_bullet_en,
  input  logic       player_en,
  input  logic       bossbullet_exist,
  output logic       collide,
  output logic       hit_pulse,
  output logic [2:0] lives,
  output logic       invuln,
  output logic       game_over,
  output logic       player_blink
);

  typedef enum logic [1:0] {
    ARMED  = 2'd0,
    HIT    = 2'd1,
    INVULN = 2'd2,
    DEAD   = 2'd3
  } state_t;

  localparam logic [2:0] LIVES_INIT = 3'(START_LIVES);
  localparam logic [9:0] THRESH     = 10'(HIT_THRESHOLD);
  localparam logic [7:0] CF_LAST    = 8'(COLLIDE_FRAMES);
  localparam logic [7:0] IF_LAST    = 8'(INVULN_FRAMES);

  state_t     state;
  logic [9:0] ov_cnt;
  logic [7:0] frame_cnt;
  logic [7:0] frame_next;
  logic       ov;

  assign ov         = pixel_valid & boss_bullet_en & player_en & bossbullet_exist;
  assign frame_next = frame_cnt + 8'd1;

  // Per-frame overlap count; a tick-cycle pixel seeds the next frame, count saturates
  always_ff @(posedge clk) begin
    if (rst) begin
      ov_cnt <= 10'd0;
    end else if (frame_tick) begin
      ov_cnt <= {9'd0, ov};
    end else if (ov && (ov_cnt != 10'h3FF)) begin
      ov_cnt <= ov_cnt + 10'd1;
    end
  end

  // Hit / invulnerability / game-over sequencer with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARMED;
      frame_cnt <= 8'd0;
      collide   <= 1'b0;
      hit_pulse <= 1'b0;
      lives     <= LIVES_INIT;
      invuln    <= 1'b0;
      game_over <= 1'b0;
    end else begin
      hit_pulse <= 1'b0;
      case (state)
        ARMED: begin
          // only the count from the completed frame is judged here
          if (frame_tick && (ov_cnt >= THRESH) && (lives != 3'd0)) begin
            hit_pulse <= 1'b1;
            collide   <= 1'b1;
            lives     <= lives - 3'd1;
            frame_cnt <= 8'd0;
            if (lives == 3'd1) begin
              state     <= DEAD;
              game_over <= 1'b1;
            end else begin
              state <= HIT;
            end
          end
        end
        HIT: begin
          if (frame_tick) begin
            if (frame_next == CF_LAST) begin
              collide   <= 1'b0;
              frame_cnt <= 8'd0;
              if (INVULN_FRAMES > 0) begin
                state  <= INVULN;
                invuln <= 1'b1;
              end else begin
                state <= ARMED;
              end
            end else begin
              frame_cnt <= frame_next;
            end
          end
        end
        INVULN: begin
          collide <= 1'b0;
          if (frame_tick) begin
            if (frame_next == IF_LAST) begin
              state     <= ARMED;
              invuln    <= 1'b0;
              frame_cnt <= 8'd0;
            end else begin
              frame_cnt <= frame_next;
            end
          end
        end
        default: begin
          // terminal: hold the game-over outputs until reset
          game_over <= 1'b1;
          collide   <= 1'b1;
          lives     <= 3'd0;
          invuln    <= 1'b0;
        end
      endcase
    end
  end

`ifdef BOSS_COLLIDE_BLINK_EN
  logic blink_q;

  // Blink toggles every fourth tick inside invulnerability, cleared on entry and exit
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_q <= 1'b0;
    end else if (state != INVULN) begin
      blink_q <= 1'b0;
    end else if (frame_tick) begin
      if (frame_next == IF_LAST) begin
        blink_q <= 1'b0;
      end else if (frame_next[1:0] == 2'd0) begin
        blink_q <= ~blink_q;
      end
    end
  end

  assign player_blink = blink_q;
`else
  assign player_blink = 1'b0;
`endif

endmodule

// File: doc/boss_bullet_collide.md
Name: boss_bullet_collide

Overview:
Consumes the boss-bullet pixel enable from the boss bullet judge stage and the player sprite pixel enable. Counts per-frame pixel overlap and commits a hit at each frame boundary. Drives the `collide` input back into the bullet judge, tracks player lives, and sequences hit, invulnerability and game-over states.

Parameters:
START_LIVES, 3, lives loaded on reset (1..7)
HIT_THRESHOLD, 4, minimum overlapping pixels in one frame to register a hit (1..1023)
COLLIDE_FRAMES, 2, frames `collide` is held high after a hit (1..255)
INVULN_FRAMES, 60, frames of invulnerability after the `collide` window (0..255)

Ports:
clk  input  1  pixel clock; single clock domain
rst  input  1  synchronous active-high reset
frame_tick  input  1  one-cycle pulse at start of each frame
pixel_valid  input  1  high during active video
boss_bullet_en  input  1  boss bullet pixel present at current x,y
player_en  input  1  player sprite pixel present at current x,y
bossbullet_exist  input  1  boss bullet alive
collide  output  1  hit indication to bullet judge (level)
hit_pulse  output  1  one-cycle pulse on hit commit
lives  output  3  remaining lives
invuln  output  1  player invulnerable
game_over  output  1  lives exhausted
player_blink  output  1  sprite blank request during invulnerability

Behaviour:
- All state updates on posedge clk. `rst` is synchronous, active high, and overrides everything.
- Reset values: collide=0, hit_pulse=0, lives=START_LIVES, invuln=0, game_over=0, player_blink=0, state=ARMED, overlap count=0, frame counter=0.
- Overlap qualifier: ov = pixel_valid & boss_bullet_en & player_en & bossbullet_exist.
- Overlap counter: 10 bits, saturates at 1023, no wrap.
- On a frame_tick cycle:
  - The evaluated value is the count accumulated before this cycle.
  - The counter then loads ov?1:0. A tick-cycle pixel belongs to the new frame.
- On a non-tick cycle: counter += ov (saturating).
- States:
  - ARMED: on frame_tick with count>=HIT_THRESHOLD:
    - next cycle hit_pulse=1 (exactly one cycle), collide=1, lives=lives-1.
    - If the new lives==0: state DEAD. Otherwise: state HIT, frame counter=0.
    - Count below threshold: no change.
  - HIT: collide=1. Frame counter increments per frame_tick. When it reaches COLLIDE_FRAMES: collide=0, frame counter=0, then:
    - INVULN_FRAMES>0: state INVULN.
    - Otherwise: state ARMED.
  - INVULN: invuln=1, collide=0. Overlaps are still counted but never committed. When the frame counter reaches INVULN_FRAMES: state ARMED, invuln=0.
  - DEAD: game_over=1, collide=1, lives=0, invuln=0. Terminal state; only rst exits.
- Hits are evaluated only in ARMED. Thresholds met in other states are discarded.
- Latency: hit committed 1 cycle after the frame_tick that evaluates the frame.
- bossbullet_exist dropping mid-frame: overlaps from that cycle onward are not counted. Earlier counts remain.
- frame_tick held high for multiple cycles: each high cycle is treated as a tick. Upstream guarantees single-cycle pulses.
- Lives never underflow: the decrement happens only from ARMED with lives>=1.
- Reset mid-HIT or mid-INVULN returns to the full reset values on the next clock.

Optional Feature:
BOSS_COLLIDE_BLINK_EN
- Defined: player_blink toggles on every 4th frame_tick while in INVULN. It is forced 0 on entry to and exit from INVULN.
- Undefined: player_blink is tied 0 and no blink logic is built. All other behaviour is identical.

Test Plan:
- Reset, then 5 overlapping pixels in frame 1 (HIT_THRESHOLD=4), then frame_tick → hit_pulse high 1 cycle after tick; lives 3→2; collide=1.
- 3 overlapping pixels, then frame_tick → no hit; lives=3; collide=0; counter reloads 0.
- After a hit: collide high for exactly 2 frame_ticks, invuln high for 60 ticks, then ARMED. Overlaps of 10 pixels/frame during INVULN → no lives change.
- Three committed hits separated by full recovery → lives 0, game_over=1, collide=1. Further overlaps → no change. rst → lives=3, game_over=0.
- Overlap asserted on the frame_tick cycle itself with 3 prior overlaps → no hit; new-frame count=1. Plus 3 more overlaps, next tick → hit.
- With BOSS_COLLIDE_BLINK_EN defined: player_blink toggles every 4 ticks during INVULN and is 0 after. Undefined: player_blink constantly 0.
